// File: rtl/udp_chk_pkg.sv
// udp_chk_pkg: shared FSM states, default header tag and field slices for the UDP test-packet checker
package udp_chk_pkg;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        DROP
    } state_t;

    localparam logic [15:0] DEF_MAGIC = 16'hA55A;

    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 16;
    localparam int SEQ_HI   = 15;
    localparam int SEQ_LO   = 0;
    localparam int IDX_HI   = 15;
    localparam int IDX_LO   = 0;

endpackage

// File: rtl/udp_rx_checker_sat_counter.sv
// sat_counter: saturating accumulator with variable increment and synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] cnt
);

    logic [W:0]   sum;
    logic [W-1:0] cnt_q, cnt_d;

    // add with carry out; a carry pins the count at all-ones
    always_comb begin
        sum   = {1'b0, cnt_q} + {1'b0, inc};
        cnt_d = clr ? '0 : (sum[W] ? '1 : sum[W-1:0]);
    end

    // count register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/udp_rx_checker.sv
// udp_rx_checker: validates received test packets, tracks sequence gaps and throttles ready
module udp_rx_checker
    import udp_chk_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          PKT_WORDS = 100,
    parameter logic [15:0] MAGIC     = DEF_MAGIC,
    parameter int          THROTTLE  = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       err_cnt,
    output logic [31:0]       lost_cnt,
    output logic              pkt_ok,
    output logic              err_pulse
);

    localparam logic [15:0] LAST = 16'(PKT_WORDS - 1);
    localparam int          TW   = THROTTLE > 0 ? $clog2(THROTTLE + 1) : 1;
    localparam logic [TW-1:0] THR_MAX = TW'(THROTTLE);

    state_t        state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   exp_q, exp_d;
    logic          bad_q, bad_d;
    logic          armed_q, armed_d;
    logic          pkt_ok_q, pkt_ok_d;
    logic          err_q, err_d;
    logic [TW-1:0] thr_q, thr_d;

    logic        acc, magic_ok, mark, hdr_ok, good, bad;
    logic [15:0] w_seq, gap;
    logic [31:0] lost_inc;

    if (DATA_W > 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^s_data[DATA_W-1:32];
    end

    assign s_ready  = (THROTTLE == 0) || (thr_q != THR_MAX);
    assign acc      = s_valid && s_ready;
    assign w_seq    = s_data[SEQ_HI:SEQ_LO];
    assign magic_ok = s_data[MAGIC_HI:MAGIC_LO] == MAGIC;
    assign mark     = bad_q || (s_data[31:0] != {seq_q, idx_q[IDX_HI:IDX_LO]});

    // free-running throttle: THROTTLE cycles ready, then one cycle not ready
    always_comb thr_d = (THROTTLE == 0 || thr_q == THR_MAX) ? '0 : thr_q + TW'(1);

    // packet FSM: header check, word-by-word payload check, drop until last
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        bad_d   = bad_q;
        hdr_ok  = 1'b0;
        good    = 1'b0;
        bad     = 1'b0;
        case (state_q)
            HDR: if (acc) begin
                if (magic_ok && !s_last) begin
                    hdr_ok  = 1'b1;
                    seq_d   = w_seq;
                    idx_d   = 16'd1;
                    bad_d   = 1'b0;
                    state_d = DATA;
                end else begin
                    bad     = 1'b1;
                    state_d = s_last ? HDR : DROP;
                end
            end
            DATA: if (acc) begin
                if (s_last) begin
                    good    = (idx_q == LAST) && !mark;
                    bad     = !good;
                    state_d = HDR;
                end else if (idx_q == LAST) begin
                    bad     = 1'b1;
                    state_d = DROP;
                end else begin
                    idx_d = idx_q + 16'd1;
                    bad_d = mark;
                end
            end
            DROP: if (acc && s_last) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    // sequence tracking and verdict pulses; clear overrides any event
    always_comb begin
        gap      = w_seq - exp_q;
        lost_inc = (hdr_ok && armed_q) ? {16'd0, gap} : 32'd0;
        armed_d  = clr ? 1'b0 : (armed_q || hdr_ok);
        exp_d    = hdr_ok ? w_seq + 16'd1 : exp_q;
        pkt_ok_d = good && !clr;
        err_d    = bad && !clr;
    end

    // state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= HDR;
            idx_q    <= '0;
            seq_q    <= '0;
            exp_q    <= '0;
            bad_q    <= 1'b0;
            armed_q  <= 1'b0;
            pkt_ok_q <= 1'b0;
            err_q    <= 1'b0;
            thr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            exp_q    <= exp_d;
            bad_q    <= bad_d;
            armed_q  <= armed_d;
            pkt_ok_q <= pkt_ok_d;
            err_q    <= err_d;
            thr_q    <= thr_d;
        end
    end

    assign pkt_ok    = pkt_ok_q;
    assign err_pulse = err_q;

    sat_counter #(.W(32)) u_pkt (
        .clk(clk), .rstn(rstn), .clr(clr), .inc({31'd0, good}), .cnt(pkt_cnt)
    );

    sat_counter #(.W(32)) u_err (
        .clk(clk), .rstn(rstn), .clr(clr), .inc({31'd0, bad}), .cnt(err_cnt)
    );

    sat_counter #(.W(32)) u_lost (
        .clk(clk), .rstn(rstn), .clr(clr), .inc(lost_inc), .cnt(lost_cnt)
    );

endmodule

// File: tb/tb_udp_rx_checker.sv
// tb_udp_rx_checker: table-driven packet checks with a verdict scoreboard on unthrottled and throttled checkers
module tb_udp_rx_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic        c0, c3, v0, v3, l0, l3;
    logic [31:0] d0, d3;
    logic        rdy0, rdy3, ok0, ok3, er0, er3;
    logic [31:0] p0, p3, e0, e3, lc0, lc3;

    int vectors = 0;
    int miscompares = 0;
    bit q0[$];
    bit q3[$];

    always #5 clk = ~clk;

    udp_rx_checker #(.DATA_W(32), .PKT_WORDS(4), .MAGIC(16'hA55A), .THROTTLE(0)) u0 (
        .clk(clk), .rstn(rstn), .clr(c0), .s_data(d0), .s_valid(v0), .s_last(l0),
        .s_ready(rdy0), .pkt_cnt(p0), .err_cnt(e0), .lost_cnt(lc0), .pkt_ok(ok0), .err_pulse(er0)
    );

    udp_rx_checker #(.DATA_W(32), .PKT_WORDS(4), .MAGIC(16'hA55A), .THROTTLE(3)) u3 (
        .clk(clk), .rstn(rstn), .clr(c3), .s_data(d3), .s_valid(v3), .s_last(l3),
        .s_ready(rdy3), .pkt_cnt(p3), .err_cnt(e3), .lost_cnt(lc3), .pkt_ok(ok3), .err_pulse(er3)
    );

    typedef struct {
        bit          clr;
        logic [15:0] seq;
        int          kind;
        logic [31:0] p;
        logic [31:0] e;
        logic [31:0] l;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input bit w, input logic [31:0] d, input bit l);
        int n = 0;
        if (w) begin d3 = d; l3 = l; v3 = 1'b1; end
        else   begin d0 = d; l0 = l; v0 = 1'b1; end
        while (!(w ? rdy3 : rdy0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic push(input bit w, input bit good);
        if (w) q3.push_back(good);
        else   q0.push_back(good);
    endtask

    // kinds: 0 good, 1 bad payload word 2, 2 early last on word 2, 3 six-word packet, 4 bad magic
    task automatic pkt(input bit w, input logic [15:0] seq, input int kind);
        int n;
        logic [15:0] lo;
        n = kind == 3 ? 6 : (kind == 2 ? 3 : 4);
        for (int k = 0; k < n; k++) begin
            lo = (kind == 1 && k == 2) ? 16'h0007 : 16'(k);
            if (kind == 4 && k == 0) push(w, 1'b0);
            if (kind == 3 && k == 3) push(w, 1'b0);
            if (kind != 3 && kind != 4 && k == n - 1) push(w, kind == 0);
            beat(w, k == 0 ? {(kind == 4 ? 16'h1234 : 16'hA55A), seq} : {seq, lo}, k == n - 1);
        end
        if (w) v3 = 1'b0;
        else   v0 = 1'b0;
    endtask

    task automatic counts(input bit w, input string tag, input logic [31:0] p, input logic [31:0] e, input logic [31:0] l);
        chk({tag, ".pkt_cnt"},  w ? p3 : p0, p);
        chk({tag, ".err_cnt"},  w ? e3 : e0, e);
        chk({tag, ".lost_cnt"}, w ? lc3 : lc0, l);
    endtask

    // verdict scoreboard: each pulse must match the next expected verdict
    always @(negedge clk) begin
        if (rstn && (ok0 || er0)) begin
            if (q0.size() == 0) chk("verdict0_unexpected", {30'd0, ok0, er0}, 32'd0);
            else chk("verdict0", {30'd0, ok0, er0}, q0.pop_front() ? 32'd2 : 32'd1);
        end
        if (rstn && (ok3 || er3)) begin
            if (q3.size() == 0) chk("verdict3_unexpected", {30'd0, ok3, er3}, 32'd0);
            else chk("verdict3", {30'd0, ok3, er3}, q3.pop_front() ? 32'd2 : 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 16'h0000, 0, 1, 0, 0};
        tbl[1]  = '{0, 16'h0001, 0, 2, 0, 0};
        tbl[2]  = '{0, 16'h0002, 0, 3, 0, 0};
        tbl[3]  = '{1, 16'h0005, 0, 1, 0, 0};
        tbl[4]  = '{0, 16'h0009, 0, 2, 0, 3};
        tbl[5]  = '{1, 16'hFFFF, 0, 1, 0, 0};
        tbl[6]  = '{0, 16'h0000, 0, 2, 0, 0};
        tbl[7]  = '{0, 16'h0001, 1, 2, 1, 0};
        tbl[8]  = '{0, 16'h0002, 0, 3, 1, 0};
        tbl[9]  = '{0, 16'h0003, 2, 3, 2, 0};
        tbl[10] = '{0, 16'h0004, 3, 3, 3, 0};
        tbl[11] = '{0, 16'h0005, 4, 3, 4, 0};
        tbl[12] = '{0, 16'h0005, 0, 4, 4, 0};
        tbl[13] = '{0, 16'h0008, 0, 5, 4, 2};

        rstn = 1'b0;
        {c0, c3, v0, v3, l0, l3} = '0;
        d0 = '0;
        d3 = '0;
        repeat (3) @(negedge clk);
        chk("reset.s_ready0", {31'd0, rdy0}, 32'd1);
        chk("reset.s_ready3", {31'd0, rdy3}, 32'd1);
        chk("reset.pulses", {28'd0, ok0, er0, ok3, er3}, 32'd0);
        counts(0, "reset0", 0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 14; i++) begin
                if (tbl[i].clr) begin
                    if (w == 1) c3 = 1'b1;
                    else        c0 = 1'b1;
                    @(negedge clk);
                    c0 = 1'b0;
                    c3 = 1'b0;
                end
                pkt(w[0], tbl[i].seq, tbl[i].kind);
                counts(w[0], $sformatf("vec%0d_%0d", w, i), tbl[i].p, tbl[i].e, tbl[i].l);
            end
        end

        beat(1, {16'hA55A, 16'd9}, 0);
        beat(1, {16'd9, 16'd1}, 0);
        beat(1, {16'd9, 16'd2}, 0);
        c3 = 1'b1;
        beat(1, {16'd9, 16'd3}, 1);
        c3 = 1'b0;
        v3 = 1'b0;
        counts(1, "clr_on_last", 0, 0, 0);
        pkt(1, 16'd10, 0);
        counts(1, "after_clr", 1, 0, 0);

        beat(1, {16'hA55A, 16'd11}, 0);
        beat(1, {16'd11, 16'd1}, 0);
        v3 = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst.s_ready", {31'd0, rdy3}, 32'd1);
        chk("midrst.pulses", {28'd0, ok0, er0, ok3, er3}, 32'd0);
        counts(1, "midrst", 0, 0, 0);
        @(negedge clk);
        chk("midrst.hold_ready", {31'd0, rdy3}, 32'd1);
        rstn = 1'b1;
        push(1, 1'b0);
        beat(1, {16'd11, 16'd2}, 0);
        beat(1, {16'd11, 16'd3}, 1);
        v3 = 1'b0;
        counts(1, "rst_tail", 0, 1, 0);
        pkt(1, 16'd12, 0);
        counts(1, "rst_next", 1, 1, 0);

        repeat (2) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
